// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// source count, id width and the round-robin picker.
package irq_ctrl_pkg;

    localparam int N_SRC = 4;
    localparam int ID_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_e;

    // First set bit of req at or after sel_start, wrapping; N_SRC is a power of two.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                                input logic [ID_W-1:0]  sel_start);
        logic [ID_W-1:0] idx;
        logic            found;
        rr_pick = sel_start;
        found   = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = sel_start + ID_W'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input followed by a
// single-cycle rising-edge pulse on the synchronized signal.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: periodic tick on source 0, three edge-triggered
// external sources, pending/overflow latches and a round-robin request FSM.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 125
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic [3:1]       src_in,
    input  logic [N_SRC-1:0] mask_in,
    input  logic             clr_all,
    input  logic             ack_valid,
    input  logic [ID_W-1:0]  ack_id,
    output logic             ei_req,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] overflow,
    output logic             tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] overflow_q, overflow_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    state_e           state_q, state_d;

    logic [N_SRC-1:0] event_w;
    logic [N_SRC-1:0] ack_clr;
    logic             ack_hit;

    assign tick  = (cnt_q == CNT_W'(DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    assign event_w[0] = tick;

    for (genvar i = 1; i < N_SRC; i++) begin : g_sync
        sync_edge_det u_sync (
            .clk_i   (clk),
            .rst_ni  (resetb),
            .async_i (src_in[i]),
            .pulse_o (event_w[i])
        );
    end

    assign ack_hit = (state_q == REQ) && ack_valid && (ack_id == irq_id_q);
    assign ack_clr = ack_hit ? (N_SRC'(1) << irq_id_q) : '0;

    // An ack racing a new event on the same source leaves the event latched
    // and the overflow flag untouched.
    always_comb begin
        state_d    = state_q;
        irq_id_d   = irq_id_q;
        ptr_d      = ptr_q;
        pending_d  = (pending_q & ~ack_clr) | event_w;
        overflow_d = (overflow_q & ~(ack_clr & ~event_w)) | (event_w & pending_q & ~ack_clr);

        case (state_q)
            IDLE: begin
                if (|(pending_q & mask_in)) begin
                    irq_id_d = rr_pick(pending_q & mask_in, ptr_q);
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (ack_hit) begin
                    ptr_d   = irq_id_q + 1'b1;
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (clr_all) begin
            pending_d  = '0;
            overflow_d = '0;
            ptr_d      = ptr_q;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cnt_q      <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
            irq_id_q   <= '0;
            ptr_q      <= '0;
            state_q    <= IDLE;
        end else begin
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            irq_id_q   <= irq_id_d;
            ptr_q      <= ptr_d;
            state_q    <= state_d;
        end
    end

    assign ei_req   = (state_q == REQ);
    assign irq_id   = irq_id_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with hand-derived
// expectations, then randomized traffic against a behavioural model.
module tb_irq_ctrl;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    logic       clk       = 1'b0;
    logic       resetb    = 1'b1;
    logic [3:1] src_in    = '0;
    logic [3:0] mask_in   = '0;
    logic       clr_all   = 1'b0;
    logic       ack_valid = 1'b0;
    logic [1:0] ack_id    = '0;
    logic       ei_req;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic       tick;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    irq_ctrl #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .src_in    (src_in),
        .mask_in   (mask_in),
        .clr_all   (clr_all),
        .ack_valid (ack_valid),
        .ack_id    (ack_id),
        .ei_req    (ei_req),
        .irq_id    (irq_id),
        .pending   (pending),
        .overflow  (overflow),
        .tick      (tick)
    );

    // Reference model: events derived from input sample history, requests
    // granted by scanning ids from the one after the last acknowledged id.
    typedef struct packed {
        logic [3:0] pend;
        logic [3:0] ovf;
        logic       busy;
        logic       gap;
        logic [1:0] id;
        logic [1:0] ptr;
    } model_t;

    model_t          m;
    logic [2:0][3:1] hist;
    int              mCycle;

    function automatic model_t model_next(input model_t cur, input logic [3:0] ev,
                                          input logic [3:0] mask, input logic clr,
                                          input logic av, input logic [1:0] aid);
        model_t nx;
        bit     acked;
        bit     mine;
        bit     found;
        int     idx;
        nx    = cur;
        acked = cur.busy && av && (aid == cur.id);
        found = 0;
        if (clr) begin
            nx.pend = '0;
            nx.ovf  = '0;
            nx.busy = 1'b0;
            nx.gap  = 1'b0;
            return nx;
        end
        for (int i = 0; i < 4; i++) begin
            mine = acked && (int'(cur.id) == i);
            if (ev[i]) begin
                if (cur.pend[i] && !mine) nx.ovf[i] = 1'b1;
                nx.pend[i] = 1'b1;
            end else if (mine) begin
                nx.pend[i] = 1'b0;
                nx.ovf[i]  = 1'b0;
            end
        end
        if (cur.gap) begin
            nx.gap = 1'b0;
        end else if (cur.busy) begin
            if (acked) begin
                nx.busy = 1'b0;
                nx.gap  = 1'b1;
                nx.ptr  = 2'((int'(cur.id) + 1) % 4);
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                idx = (int'(cur.ptr) + k) % 4;
                if (!found && cur.pend[idx] && mask[idx]) begin
                    found   = 1;
                    nx.id   = 2'(idx);
                    nx.busy = 1'b1;
                end
            end
        end
        return nx;
    endfunction

    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            m      <= '0;
            hist   <= '0;
            mCycle <= 0;
        end else begin
            m      <= model_next(m, {hist[1] & ~hist[2], (mCycle % DIV) == DIV - 1},
                                 mask_in, clr_all, ack_valid, ack_id);
            hist   <= {hist[1:0], src_in};
            mCycle <= mCycle + 1;
        end
    end

    task automatic do_reset();
        resetb    = 1'b0;
        src_in    = '0;
        mask_in   = '0;
        clr_all   = 1'b0;
        ack_valid = 1'b0;
        ack_id    = '0;
        repeat (2) @(negedge clk);
        resetb = 1'b1;
    endtask

    task automatic test_reset();
        resetb    = 1'b0;
        src_in    = '0;
        mask_in   = 4'hF;
        repeat (2) @(negedge clk);
        checks++;
        if (ei_req !== 1'b0 || irq_id !== 2'd0 || tick !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got ei_req=%b irq_id=%0d tick=%b want 0 0 0", ei_req, irq_id, tick);
        end
        checks++;
        if (pending !== 4'b0000 || overflow !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_flags got pending=%b overflow=%b want 0000 0000", pending, overflow);
        end
    endtask

    task automatic test_tick();
        do_reset();
        for (int n = 0; n < 30; n++) begin
            checks++;
            if (tick !== ((n % 10) == 9)) begin
                failures++;
                $display("[TB] FAIL tick_period cycle=%0d got=%b want=%b", n, tick, (n % 10) == 9);
            end
            checks++;
            if (ei_req !== 1'b0) begin
                failures++;
                $display("[TB] FAIL tick_masked_req cycle=%0d got=%b want=0", n, ei_req);
            end
            checks++;
            if (pending !== ((n >= 10) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("[TB] FAIL tick_pending cycle=%0d got=%b want=%b", n, pending,
                         (n >= 10) ? 4'b0001 : 4'b0000);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        do_reset();
        mask_in   = 4'hF;
        src_in[2] = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (pending !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL single_early got pending=%b want 0000", pending);
        end
        @(negedge clk);
        checks++;
        if (pending !== 4'b0100 || ei_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_latch got pending=%b ei_req=%b want 0100 0", pending, ei_req);
        end
        @(negedge clk);
        checks++;
        if (ei_req !== 1'b1 || irq_id !== 2'd2) begin
            failures++;
            $display("[TB] FAIL single_req got ei_req=%b irq_id=%0d want 1 2", ei_req, irq_id);
        end
        ack_valid = 1'b1;
        ack_id    = 2'd2;
        @(negedge clk);
        ack_valid = 1'b0;
        checks++;
        if (ei_req !== 1'b0 || pending !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL single_gap got ei_req=%b pending=%b want 0 0000", ei_req, pending);
        end
        @(negedge clk);
        checks++;
        if (ei_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_after_gap got ei_req=%b want 0", ei_req);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        int waited;
        do_reset();
        mask_in = 4'hF;
        src_in  = 3'b111;
        repeat (3) @(negedge clk);
        checks++;
        if (pending !== 4'b1110) begin
            failures++;
            $display("[TB] FAIL rr_pending got=%b want=1110", pending);
        end
        for (int g = 0; g < 4; g++) begin
            waited = 0;
            while (ei_req !== 1'b1 && waited < 8) begin
                @(negedge clk);
                waited++;
            end
            checks++;
            if (ei_req !== 1'b1) begin
                failures++;
                $display("[TB] FAIL rr_timeout grant=%0d got ei_req=%b want 1", g, ei_req);
            end
            checks++;
            if (irq_id !== order[g]) begin
                failures++;
                $display("[TB] FAIL rr_order grant=%0d got=%0d want=%0d", g, irq_id, order[g]);
            end
            if (order[g] == 2'd2) begin
                mask_in = 4'h0;
                @(negedge clk);
                checks++;
                if (ei_req !== 1'b1 || irq_id !== 2'd2) begin
                    failures++;
                    $display("[TB] FAIL rr_mask_hold got ei_req=%b irq_id=%0d want 1 2", ei_req, irq_id);
                end
                mask_in = 4'hF;
            end
            ack_valid = 1'b1;
            ack_id    = order[g];
            @(negedge clk);
            ack_valid = 1'b0;
            checks++;
            if (ei_req !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rr_gap grant=%0d got ei_req=%b want 0", g, ei_req);
            end
        end
        checks++;
        if (pending !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL rr_drained got pending=%b want 0000", pending);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        mask_in   = 4'hF;
        src_in[3] = 1'b1;
        repeat (2) @(negedge clk);
        src_in[3] = 1'b0;
        repeat (2) @(negedge clk);
        src_in[3] = 1'b1;
        checks++;
        if (ei_req !== 1'b1 || irq_id !== 2'd3) begin
            failures++;
            $display("[TB] FAIL ovf_req got ei_req=%b irq_id=%0d want 1 3", ei_req, irq_id);
        end
        @(negedge clk);
        ack_valid = 1'b1;
        ack_id    = 2'd2;
        @(negedge clk);
        ack_valid = 1'b0;
        checks++;
        if (ei_req !== 1'b1 || irq_id !== 2'd3 || pending !== 4'b1000 || overflow !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL ovf_bad_ack got ei_req=%b irq_id=%0d pending=%b overflow=%b want 1 3 1000 0000",
                     ei_req, irq_id, pending, overflow);
        end
        @(negedge clk);
        checks++;
        if (overflow !== 4'b1000 || pending !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL ovf_set got overflow=%b pending=%b want 1000 1000", overflow, pending);
        end
        ack_valid = 1'b1;
        ack_id    = 2'd3;
        @(negedge clk);
        ack_valid = 1'b0;
        checks++;
        if (overflow !== 4'b0000 || pending !== 4'b0000 || ei_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_clear got overflow=%b pending=%b ei_req=%b want 0000 0000 0",
                     overflow, pending, ei_req);
        end
    endtask

    task automatic test_clr_and_reset();
        do_reset();
        mask_in   = 4'hF;
        src_in[2] = 1'b1;
        repeat (2) @(negedge clk);
        src_in[1] = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ei_req !== 1'b1 || irq_id !== 2'd2) begin
            failures++;
            $display("[TB] FAIL clr_pre_req got ei_req=%b irq_id=%0d want 1 2", ei_req, irq_id);
        end
        ack_valid = 1'b1;
        ack_id    = 2'd2;
        clr_all   = 1'b1;
        @(negedge clk);
        ack_valid = 1'b0;
        clr_all   = 1'b0;
        checks++;
        if (pending !== 4'b0000 || overflow !== 4'b0000 || ei_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clr_all got pending=%b overflow=%b ei_req=%b want 0000 0000 0",
                     pending, overflow, ei_req);
        end
        @(negedge clk);
        checks++;
        if (ei_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clr_idle got ei_req=%b want 0", ei_req);
        end
        src_in[3] = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tick !== 1'b1 || pending !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL clr_tick_kept got tick=%b pending=%b want 1 1000", tick, pending);
        end
        @(negedge clk);
        checks++;
        if (ei_req !== 1'b1 || irq_id !== 2'd3) begin
            failures++;
            $display("[TB] FAIL clr_ptr_kept got ei_req=%b irq_id=%0d want 1 3", ei_req, irq_id);
        end
        resetb = 1'b0;
        #1;
        checks++;
        if (ei_req !== 1'b0 || pending !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL async_reset got ei_req=%b pending=%b want 0 0000", ei_req, pending);
        end
        @(negedge clk);
        resetb = 1'b1;
    endtask

    task automatic test_random();
        int j;
        do_reset();
        mask_in = 4'hF;
        for (int n = 0; n < 600; n++) begin
            checks++;
            if (ei_req !== m.busy) begin
                failures++;
                $display("[TB] FAIL rand_ei_req cycle=%0d got=%b want=%b", n, ei_req, m.busy);
            end
            checks++;
            if (tick !== ((mCycle % DIV) == DIV - 1)) begin
                failures++;
                $display("[TB] FAIL rand_tick cycle=%0d got=%b want=%b", n, tick, (mCycle % DIV) == DIV - 1);
            end
            checks++;
            if (pending !== m.pend) begin
                failures++;
                $display("[TB] FAIL rand_pending cycle=%0d got=%b want=%b", n, pending, m.pend);
            end
            checks++;
            if (overflow !== m.ovf) begin
                failures++;
                $display("[TB] FAIL rand_overflow cycle=%0d got=%b want=%b", n, overflow, m.ovf);
            end
            if (m.busy) begin
                checks++;
                if (irq_id !== m.id) begin
                    failures++;
                    $display("[TB] FAIL rand_irq_id cycle=%0d got=%0d want=%0d", n, irq_id, m.id);
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                j = $urandom_range(1, 3);
                src_in[j] = ~src_in[j];
            end
            if ($urandom_range(0, 19) == 0) mask_in = 4'($urandom);
            ack_valid = ($urandom_range(0, 2) == 0);
            ack_id    = ($urandom_range(0, 3) != 0) ? m.id : 2'($urandom);
            clr_all   = ($urandom_range(0, 49) == 0);
            @(negedge clk);
        end
        ack_valid = 1'b0;
        clr_all   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_tick();
        test_single();
        test_round_robin();
        test_overflow();
        test_clr_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
